// File: rtl/lector_destinos_pkg.sv
// Shared constants and state encoding for the destination-side reader and
// the other full_logic merge points.
package lector_destinos_pkg;
    localparam int DATA_WIDTH = 6;
    localparam int DEST_BIT   = 4;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    localparam logic SRC_D0 = 1'b0;
    localparam logic SRC_D1 = 1'b1;
endpackage

// File: rtl/lector_destinos_if.sv
// FIFO pop/empty side plus the merged output stream of the destination reader.
interface lector_destinos_if
    import lector_destinos_pkg::*;
#(
    parameter int data_width = DATA_WIDTH
);
    logic                  empty_fifo_D0;
    logic                  empty_fifo_D1;
    logic [data_width-1:0] data_in_D0;
    logic [data_width-1:0] data_in_D1;
    logic                  D0_pop;
    logic                  D1_pop;
    logic                  ready_in;
    logic [data_width-1:0] data_out;
    logic                  valid_out;

    modport slave (
        input  empty_fifo_D0, empty_fifo_D1, data_in_D0, data_in_D1, ready_in,
        output D0_pop, D1_pop, data_out, valid_out
    );

    modport master (
        output empty_fifo_D0, empty_fifo_D1, data_in_D0, data_in_D1, ready_in,
        input  D0_pop, D1_pop, data_out, valid_out
    );
endinterface

// File: rtl/lector_destinos_rr_arbiter_2.sv
// Two-requester round-robin: on contention the one not served last wins.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last_served,
    output logic [1:0] grant
);
    always_comb begin
        grant = req;
        if (req == 2'b11)
            grant = last_served ? 2'b01 : 2'b10;
    end
endmodule

// File: rtl/lector_destinos.sv
// Drains the D0/D1 destination FIFOs into one registered stream, checking the
// destination bit of each word and counting words per destination.
module lector_destinos
    import lector_destinos_pkg::*;
#(
    parameter int data_width  = DATA_WIDTH,
    parameter int count_width = 8,
    parameter int dest_bit    = DEST_BIT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   init,
    lector_destinos_if.slave       bus,
    output logic [count_width-1:0] count_D0,
    output logic [count_width-1:0] count_D1,
    output logic                   idle_out,
    output logic                   active_out,
    output logic                   error_out
);
    localparam logic [count_width-1:0] CNT_MAX = '1;

    state_t                state, state_nxt;
    logic                  last_served;
    logic                  pop_en, pop, mismatch;
    logic [1:0]            req, grant;
    logic [data_width-1:0] word, data_q;
    logic                  valid_q;

    // Pops are gated by state so an asserted reset withdraws them at once.
    assign pop_en = ((state == ST_IDLE) || (state == ST_ACTIVE)) && bus.ready_in;
    assign req    = {~bus.empty_fifo_D1, ~bus.empty_fifo_D0} & {2{pop_en}};

    rr_arbiter_2 u_arb (
        .req        (req),
        .last_served(last_served),
        .grant      (grant)
    );

    assign bus.D0_pop = grant[0];
    assign bus.D1_pop = grant[1];
    assign pop        = |grant;
    assign word       = grant[1] ? bus.data_in_D1 : bus.data_in_D0;
    assign mismatch   = (grant[0] &  bus.data_in_D0[dest_bit])
                      | (grant[1] & ~bus.data_in_D1[dest_bit]);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET:  if (init) state_nxt = ST_INIT;
            ST_INIT:   state_nxt = ST_IDLE;
            ST_IDLE,
            ST_ACTIVE: begin
                if (mismatch)
                    state_nxt = ST_ERROR;
                else if (pop)
                    state_nxt = ST_ACTIVE;
                else if (bus.empty_fifo_D0 && bus.empty_fifo_D1)
                    state_nxt = ST_IDLE;
            end
            ST_ERROR:  if (init) state_nxt = ST_INIT;
            default:   state_nxt = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_RESET;
            last_served <= SRC_D1;
            count_D0    <= '0;
            count_D1    <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            state   <= state_nxt;
            valid_q <= pop;
            if (pop)
                data_q <= word;
            if (state == ST_INIT) begin
                last_served <= SRC_D1;
                count_D0    <= '0;
                count_D1    <= '0;
            end else begin
                if (pop)
                    last_served <= grant[1];
                if (grant[0] && count_D0 != CNT_MAX)
                    count_D0 <= count_D0 + 1'b1;
                if (grant[1] && count_D1 != CNT_MAX)
                    count_D1 <= count_D1 + 1'b1;
            end
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign idle_out      = (state == ST_IDLE);
    assign active_out    = (state == ST_ACTIVE);
    assign error_out     = (state == ST_ERROR);
endmodule

// File: tb/tb_lector_destinos.sv
// Directed bench: FIFO models feed D0/D1, outputs checked with immediate asserts.
module tb_lector_destinos;
    logic       clk = 1'b0;
    logic       reset;
    logic       init;
    logic [7:0] count_D0, count_D1;
    logic       idle_out, active_out, error_out;
    int         checks = 0;
    int         errors = 0;

    logic [5:0] mem0 [512];
    logic [5:0] mem1 [512];
    int         wp0 = 0, wp1 = 0;
    int         rp0 = 0, rp1 = 0;

    lector_destinos_if #(.data_width(6)) bus ();

    lector_destinos dut (
        .clk       (clk),
        .reset     (reset),
        .init      (init),
        .bus       (bus),
        .count_D0  (count_D0),
        .count_D1  (count_D1),
        .idle_out  (idle_out),
        .active_out(active_out),
        .error_out (error_out)
    );

    always #5 clk = ~clk;

    assign bus.empty_fifo_D0 = (wp0 == rp0);
    assign bus.empty_fifo_D1 = (wp1 == rp1);
    assign bus.data_in_D0    = mem0[rp0[8:0]];
    assign bus.data_in_D1    = mem1[rp1[8:0]];

    always @(posedge clk) begin
        if (bus.D0_pop) rp0 <= rp0 + 1;
        if (bus.D1_pop) rp1 <= rp1 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push0(input logic [5:0] w);
        mem0[wp0[8:0]] = w;
        wp0++;
    endtask

    task automatic push1(input logic [5:0] w);
        mem1[wp1[8:0]] = w;
        wp1++;
    endtask

    task automatic reset_init();
        bus.ready_in = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        init  = 1'b1;
        @(negedge clk);
        init = 1'b0;
        @(negedge clk);
    endtask

    task automatic fill3();
        push0(6'b100000); push0(6'b100001); push0(6'b100010);
        push1(6'b110000); push1(6'b110001); push1(6'b110010);
    endtask

    // Runs one ready_in pattern over a 3+3 fill; pops must alternate D0,D1 from a fresh init.
    task automatic stream(input logic [15:0] pat, input int n);
        logic [5:0] exp_w [6];
        int   idx;
        logic prev;
        exp_w = '{6'b100000, 6'b110000, 6'b100001, 6'b110001, 6'b100010, 6'b110010};
        idx = 0;
        prev = 1'b0;
        for (int c = 0; c < n; c++) begin
            bus.ready_in = pat[c];
            #1;
            chk("stream_pop_d0", bus.D0_pop, pat[c] && (idx % 2 == 0));
            chk("stream_pop_d1", bus.D1_pop, pat[c] && (idx % 2 == 1));
            chk("stream_valid", bus.valid_out, prev);
            chk("stream_active", active_out, c > 0);
            if (prev) chk("stream_data", bus.data_out, exp_w[idx-1]);
            prev = pat[c];
            if (pat[c]) idx++;
            @(negedge clk);
        end
        #1;
        chk("stream_last_valid", bus.valid_out, 1);
        chk("stream_last_data", bus.data_out, 6'b110010);
        chk("stream_cnt_d0", count_D0, 3);
        chk("stream_cnt_d1", count_D1, 3);
        bus.ready_in = 1'b0;
        @(negedge clk);
        #1;
        chk("stream_back_idle", idle_out, 1);
        chk("stream_valid_drop", bus.valid_out, 0);
    endtask

    initial begin
        reset = 1'b0;
        init  = 1'b0;
        bus.ready_in = 1'b0;
        #1;
        chk("rst_pop_d0", bus.D0_pop, 0);
        chk("rst_pop_d1", bus.D1_pop, 0);
        chk("rst_data", bus.data_out, 0);
        chk("rst_valid", bus.valid_out, 0);
        chk("rst_cnt_d0", count_D0, 0);
        chk("rst_cnt_d1", count_D1, 0);
        chk("rst_flags", {idle_out, active_out, error_out}, 0);

        repeat (4) @(negedge clk);
        reset = 1'b1;
        init  = 1'b1;
        @(negedge clk);
        #1;
        chk("init_flags", {idle_out, active_out, error_out}, 0);
        init = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_after_init", {idle_out, active_out, error_out}, 3'b100);
        chk("idle_valid", bus.valid_out, 0);
        chk("idle_data", bus.data_out, 0);

        // single D0 word
        push0(6'b100101);
        bus.ready_in = 1'b1;
        #1;
        chk("single_pop_d0", bus.D0_pop, 1);
        chk("single_pop_d1", bus.D1_pop, 0);
        @(negedge clk);
        #1;
        chk("single_valid", bus.valid_out, 1);
        chk("single_data", bus.data_out, 6'b100101);
        chk("single_cnt_d0", count_D0, 1);
        chk("single_active", active_out, 1);
        chk("single_no_pop", bus.D0_pop, 0);
        @(negedge clk);
        #1;
        chk("single_idle", idle_out, 1);
        chk("single_valid_drop", bus.valid_out, 0);
        chk("single_data_hold", bus.data_out, 6'b100101);

        // back-to-back alternation, then a 4-cycle ready_in stall mid-stream
        reset_init();
        fill3();
        stream(16'h003F, 6);
        reset_init();
        fill3();
        stream(16'h03C3, 10);

        // destination mismatch on D0
        push0(6'b110101);
        bus.ready_in = 1'b1;
        #1;
        chk("err_pop_d0", bus.D0_pop, 1);
        @(negedge clk);
        #1;
        chk("err_flag", error_out, 1);
        chk("err_active", active_out, 0);
        chk("err_valid", bus.valid_out, 1);
        chk("err_data", bus.data_out, 6'b110101);
        push1(6'b110011);
        #1;
        chk("err_no_pop_d1", bus.D1_pop, 0);
        chk("err_no_pop_d0", bus.D0_pop, 0);
        @(negedge clk);
        #1;
        chk("err_sticky", error_out, 1);
        chk("err_valid_drop", bus.valid_out, 0);
        bus.ready_in = 1'b0;
        init = 1'b1;
        @(negedge clk);
        #1;
        chk("err_to_init", {idle_out, active_out, error_out}, 0);
        init = 1'b0;
        @(negedge clk);
        #1;
        chk("reinit_idle", idle_out, 1);
        chk("reinit_cnt_d0", count_D0, 0);
        chk("reinit_cnt_d1", count_D1, 0);

        // saturation: 1 pending + 300 new D1 words
        for (int i = 0; i < 300; i++) push1({2'b01, 4'(i)});
        bus.ready_in = 1'b1;
        for (int c = 1; c <= 280; c++) begin
            @(negedge clk);
            #1;
            if (c == 200) chk("sat_cnt_200", count_D1, 200);
        end
        chk("sat_cnt_max", count_D1, 255);
        chk("sat_pop_d1", bus.D1_pop, 1);
        chk("sat_valid", bus.valid_out, 1);

        // asynchronous reset mid-stream
        reset = 1'b0;
        #1;
        chk("async_pop_d1", bus.D1_pop, 0);
        chk("async_valid", bus.valid_out, 0);
        chk("async_data", bus.data_out, 0);
        chk("async_cnt_d1", count_D1, 0);
        chk("async_flags", {idle_out, active_out, error_out}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lector_destinos.md
# lector_destinos

Destination-side reader for the full_logic transmission path: drains the D0 and D1 output FIFOs through their pop/empty interface and merges them into one registered output stream toward the downstream consumer. A 2-way round-robin arbiter gives D0 and D1 equal service. The block checks that each popped word's destination bit matches the FIFO it came from and keeps saturating per-destination word counts. It reports status through the same idle/active/error flag set that full_logic uses.

## Interface
Parameters:
- data_width, 6, width of FIFO words and of data_out.
- count_width, 8, width of per-destination counters.
- dest_bit, 4, index of the destination bit in a word (0 = D0, 1 = D1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; reset=0 forces the reset state immediately.
- init  input  1  initialization request (level).
- ready_in  input  1  consumer can accept a word this cycle.
- empty_fifo_D0, empty_fifo_D1  input  1 each  FIFO empty flags.
- data_in_D0, data_in_D1  input  data_width each  FIFO head words; first-word-fall-through, valid while not empty.
- D0_pop, D1_pop  output  1 each  combinational pop strobes; at most one high per cycle.
- data_out  output  data_width  registered merged word.
- valid_out  output  1  data_out holds a word popped in the previous cycle.
- count_D0, count_D1  output  count_width each  words popped per destination.
- idle_out, active_out, error_out  output  1 each  one-hot state flags; all 0 in RESET and INIT.

## Operation
- States: RESET, INIT, IDLE, ACTIVE, ERROR.
- RESET → INIT when init=1.
- INIT lasts one cycle: clears counters and sets last_served=D1. It then goes to IDLE.
- IDLE → ACTIVE in any cycle where a pop occurs.
- ACTIVE → IDLE in any cycle with no pop and both FIFOs empty. ACTIVE stays in ACTIVE while ready_in=0 and data is pending.
- Any popped word with bit dest_bit ≠ its source (D0 expects 0, D1 expects 1) → ERROR on the next edge. The mismatch check has priority over the IDLE/ACTIVE transitions.
- ERROR is sticky. No pops occur in ERROR. Only init=1 (→ INIT) or reset=0 leaves it.
- Pop rule: pops are enabled only in IDLE and ACTIVE, and only with ready_in=1.
  - If exactly one FIFO is non-empty, pop that FIFO.
  - If both are non-empty, pop the FIFO that is not last_served.
  - last_served updates on every pop.
- Output: on a pop, data_out ← popped word and valid_out ← 1 on the next edge. Otherwise valid_out ← 0 and data_out holds its value.
- The erroneous word is still presented on data_out with valid_out=1. The error is flagged from the next cycle.
- Counters: increment count_Dx on each Dx pop and saturate at 2^count_width−1 (255). They do not wrap.
- Simultaneous init=1 and a pending pop in IDLE/ACTIVE: init is ignored outside RESET/ERROR and the pop proceeds.

## Timing
- Reset values: D0_pop=D1_pop=0, data_out=0, valid_out=0, count_D0=count_D1=0, idle_out=active_out=error_out=0, state RESET, last_served=D1.
- Latency: pop in cycle N → data_out/valid_out visible after edge N+1.
- Throughput: one word per cycle while ready_in=1 and data is available. With both FIFOs full, pops alternate D0,D1,D0,…
- Pops are combinational from the current state, empty flags and ready_in. The FIFO must accept a pop in the same cycle its empty flag is 0.
- Reset mid-transfer: the outputs drop asynchronously to their reset values. The pop issued in that cycle is withdrawn, since pops are gated by state.
- ready_in is sampled only to gate pops. valid_out is not held waiting for ready_in; the consumer raises ready_in only when it can absorb the word.

## Structure
- Shared package holds:
  - state encoding constants: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4 (3 bits);
  - DATA_WIDTH=6;
  - DEST_BIT=4.
- Sub-module rr_arbiter_2: inputs req[1:0] and last_served; outputs grant[1:0] (one-hot or zero). Reused by the other merge points in the design.
- Top level holds the state machine, the output register, and two saturating counters.

## Test plan
- Reset low 4 cycles, then reset=1 and init=1 → INIT for one cycle, then idle_out=1 with all outputs 0. Reset values are checked at time 0.
- D0 holds 6'b100101, D1 empty, ready_in=1 → D0_pop for one cycle, data_out=6'b100101 with valid_out=1 one cycle later, count_D0=1, active_out then idle_out.
- Both FIFOs hold 3 words (D0: 6'b1000xx, D1: 6'b1100xx) → pops ordered D0,D1,D0,D1,D0,D1 over 6 consecutive cycles, count_D0=count_D1=3.
- Same fill with ready_in=0 for 4 cycles mid-stream → no pops, valid_out=0 and no words lost; order resumes where it stopped.
- D0 head word 6'b110101 (dest bit 1) → word output once, then error_out=1, no further pops. Pulse init → INIT, then IDLE with counters cleared.
- Push 300 words into D1 → count_D1 saturates at 255; reset=0 mid-stream clears every output asynchronously.
